// File: rtl/load_store_access_unit_pkg.sv
// ============================================================================
// Module      : load_store_access_unit_pkg
// Description : Shared access-order encodings, lane-mask rule and FSM states
//               for the load/store access unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_access_unit_pkg;

    localparam logic [1:0] ORDER_BYTE = 2'b00;
    localparam logic [1:0] ORDER_HALF = 2'b01;
    localparam logic [1:0] ORDER_WORD = 2'b10;
    localparam logic [1:0] ORDER_RAW  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } ldst_state_t;

    // Big-endian lanes: mask bit 3 covers the byte at address offset 0.
    function automatic logic [3:0] lane_mask(
        input logic [1:0] order,
        input logic [1:0] addr_lo,
        input logic [3:0] raw_mask
    );
        case (order)
            ORDER_BYTE: lane_mask = 4'b1000 >> addr_lo;
            ORDER_HALF: lane_mask = addr_lo[1] ? 4'b0011 : 4'b1100;
            ORDER_WORD: lane_mask = 4'b1111;
            default:    lane_mask = raw_mask;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_access_unit_lane_format.sv
// ============================================================================
// Module      : load_store_lane_format
// Description : Combinational write-data replication, byte-mask generation,
//               bus address alignment and read-data extraction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_lane_format
    import load_store_access_unit_pkg::*;
(
    input  logic [1:0]  order,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  raw_mask,
    input  logic [31:0] rd_raw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_mask,
    output logic [31:0] rd_data
);

    logic [31:0] w_byte_shift;
    logic [31:0] w_half_shift;

    // (3 - offset) equals the bitwise inverse of a 2-bit offset.
    assign w_byte_shift = rd_raw >> {~addr[1:0], 3'b000};
    assign w_half_shift = rd_raw >> {~addr[1], 4'b0000};

    always_comb begin
        mem_mask = lane_mask(order, addr[1:0], raw_mask);
        mem_addr = (order == ORDER_RAW) ? addr : {addr[31:2], 2'b00};
        case (order)
            ORDER_BYTE: begin
                mem_data = {4{wr_data[7:0]}};
                rd_data  = {24'd0, w_byte_shift[7:0]};
            end
            ORDER_HALF: begin
                mem_data = {2{wr_data[15:0]}};
                rd_data  = {16'd0, w_half_shift[15:0]};
            end
            default: begin
                mem_data = wr_data;
                rd_data  = rd_raw;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_access_unit.sv
// ============================================================================
// Module      : load_store_access_unit
// Description : Owns the single outstanding data-memory transaction: latches a
//               request, issues it on DATAIO and returns the formatted result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_access_unit
    import load_store_access_unit_pkg::*;
(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iFLUSH,
    input  logic        iLDST_REQ,
    output logic        oLDST_BUSY,
    input  logic [1:0]  iLDST_ORDER,
    input  logic [3:0]  iLDST_MASK,
    input  logic        iLDST_RW,
    input  logic [13:0] iLDST_TID,
    input  logic [1:0]  iLDST_MMUMOD,
    input  logic [31:0] iLDST_PDT,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    output logic        oLDST_VALID,
    output logic        oLDST_PAGEFAULT,
    output logic [13:0] oLDST_MMU_FLAGS,
    output logic [31:0] oLDST_DATA,
    output logic        oDATAIO_REQ,
    input  logic        iDATAIO_BUSY,
    output logic [1:0]  oDATAIO_ORDER,
    output logic [3:0]  oDATAIO_MASK,
    output logic        oDATAIO_RW,
    output logic [13:0] oDATAIO_TID,
    output logic [1:0]  oDATAIO_MMUMOD,
    output logic [31:0] oDATAIO_PDT,
    output logic [31:0] oDATAIO_ADDR,
    output logic [31:0] oDATAIO_DATA,
    input  logic        iDATAIO_REQ,
    input  logic        iDATAIO_PAGEFAULT,
    input  logic [13:0] iDATAIO_MMU_FLAGS,
    input  logic [31:0] iDATAIO_DATA
);

    ldst_state_t r_state, w_next_state;
    logic        w_accept, w_capture;

    logic [1:0]  r_order;
    logic        r_rw;
    logic [13:0] r_tid;
    logic [1:0]  r_mmumod;
    logic [31:0] r_pdt, r_addr, r_wdata;
    logic [3:0]  r_raw_mask;

    logic        r_valid, r_pagefault;
    logic [13:0] r_mmu_flags;
    logic [31:0] r_rdata;

    logic [31:0] w_mem_addr, w_mem_data, w_rd_data;
    logic [3:0]  w_mem_mask;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iLDST_REQ && !iFLUSH) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Once memory has taken the request its response must be drained.
                if (!iDATAIO_BUSY)
                    w_next_state = iFLUSH ? ST_DRAIN : ST_WAIT;
                else if (iFLUSH)
                    w_next_state = ST_IDLE;
            end
            ST_WAIT: begin
                if (iDATAIO_REQ) begin
                    w_capture    = !iFLUSH;
                    w_next_state = ST_IDLE;
                end else if (iFLUSH) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (iDATAIO_REQ)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            r_state     <= ST_IDLE;
            r_order     <= 2'd0;
            r_rw        <= 1'b0;
            r_tid       <= 14'd0;
            r_mmumod    <= 2'd0;
            r_pdt       <= 32'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_raw_mask  <= 4'd0;
            r_valid     <= 1'b0;
            r_pagefault <= 1'b0;
            r_mmu_flags <= 14'd0;
            r_rdata     <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_valid <= w_capture;
            if (w_accept) begin
                r_order    <= iLDST_ORDER;
                r_rw       <= iLDST_RW;
                r_tid      <= iLDST_TID;
                r_mmumod   <= iLDST_MMUMOD;
                r_pdt      <= iLDST_PDT;
                r_addr     <= iLDST_ADDR;
                r_wdata    <= iLDST_DATA;
                r_raw_mask <= iLDST_MASK;
            end
            if (w_capture) begin
                r_pagefault <= iDATAIO_PAGEFAULT;
                r_mmu_flags <= iDATAIO_MMU_FLAGS;
                r_rdata     <= iDATAIO_PAGEFAULT ? 32'd0 : w_rd_data;
            end
        end
    end

    load_store_lane_format u_lane_format (
        .order    (r_order),
        .addr     (r_addr),
        .wr_data  (r_wdata),
        .raw_mask (r_raw_mask),
        .rd_raw   (iDATAIO_DATA),
        .mem_addr (w_mem_addr),
        .mem_data (w_mem_data),
        .mem_mask (w_mem_mask),
        .rd_data  (w_rd_data)
    );

    assign oLDST_BUSY      = (r_state != ST_IDLE);
    assign oLDST_VALID     = r_valid;
    assign oLDST_PAGEFAULT = r_pagefault;
    assign oLDST_MMU_FLAGS = r_mmu_flags;
    assign oLDST_DATA      = r_rdata;

    assign oDATAIO_REQ    = (r_state == ST_ISSUE);
    assign oDATAIO_ORDER  = r_order;
    // Idle mask is forced low so a cleared request never shows an enabled lane.
    assign oDATAIO_MASK   = (r_state == ST_IDLE) ? 4'd0 : w_mem_mask;
    assign oDATAIO_RW     = r_rw;
    assign oDATAIO_TID    = r_tid;
    assign oDATAIO_MMUMOD = r_mmumod;
    assign oDATAIO_PDT    = r_pdt;
    assign oDATAIO_ADDR   = w_mem_addr;
    assign oDATAIO_DATA   = w_mem_data;

endmodule

`default_nettype wire

// File: doc/load_store_access_unit.md
# load_store_access_unit

Sits directly downstream of the load/store pipe arbiter and owns the single outstanding data-memory transaction. It accepts one request from the arbiter's LDST port, latches it, formats the write data and byte mask per access order, and issues it on the DATAIO bus. It then waits for the response, extracts and zero-extends read data, and returns a one-cycle VALID pulse with data, pagefault and MMU flags. A flush input cancels an in-flight access without corrupting the bus handshake.

## Interface
Parameters:
- none (widths fixed by the core: 32-bit address/data, 14-bit TID/flags)

Ports:
- iCLOCK  in  1  core clock
- iRESET_SYNC  in  1  synchronous reset, active-high
- iFLUSH  in  1  cancel the current access
- iLDST_REQ  in  1  request from the arbiter
- oLDST_BUSY  out  1  high whenever state != IDLE
- iLDST_ORDER  in  2  access order: 00 byte, 01 half, 10 word, 11 none (raw)
- iLDST_MASK  in  4  raw mask, used only when ORDER=11
- iLDST_RW  in  1  access direction: 0 read, 1 write
- iLDST_TID, iLDST_MMUMOD, iLDST_PDT  in  14/2/32  passed through unchanged
- iLDST_ADDR  in  32  byte address
- iLDST_DATA  in  32  write data, right-justified
- oLDST_VALID  out  1  one-cycle completion pulse
- oLDST_PAGEFAULT  out  1  pagefault flag, qualified by VALID
- oLDST_MMU_FLAGS  out  14  MMU flags, qualified by VALID
- oLDST_DATA  out  32  read data, right-justified and zero-extended
- oDATAIO_REQ  out  1  request to memory; held until accepted
- iDATAIO_BUSY  in  1  memory not ready; request is accepted when REQ && !BUSY
- oDATAIO_ORDER/MASK/RW/TID/MMUMOD/PDT  out  2/4/1/14/2/32  latched request fields
- oDATAIO_ADDR  out  32  word-aligned address: {addr[31:2],2'b00}; for ORDER=11, the raw address
- oDATAIO_DATA  out  32  lane-formatted write data
- iDATAIO_REQ  in  1  response valid
- iDATAIO_PAGEFAULT, iDATAIO_MMU_FLAGS, iDATAIO_DATA  in  1/14/32  response payload

## Operation
States:
- IDLE: on iLDST_REQ, latch all fields and go to ISSUE.
- ISSUE: oDATAIO_REQ=1. When !iDATAIO_BUSY, go to WAIT.
- WAIT: on iDATAIO_REQ, capture the response and go to IDLE.
- DRAIN: on iDATAIO_REQ, discard the response and go to IDLE.

Lane convention: big-endian. Byte at addr[1:0]=0 is bits[31:24]; mask bit3 covers bits[31:24].

Write path:
- Byte: data[7:0] replicated into all four lanes; mask = 4'b1000 >> addr[1:0].
- Half: data[15:0] replicated into both halves; mask = addr[1] ? 0011 : 1100.
- Word: data as-is; mask = 1111.
- ORDER=11: data and iLDST_MASK pass through unchanged.
- Reads use the same mask rule.

Read path: shift right by (3-addr[1:0])*8 for byte and (1-addr[1])*16 for half, zero-extend to 32 bits; word and ORDER=11 are unshifted.

Misaligned half/word accesses: addr[0] (half) or addr[1:0] (word) are ignored. No fault is raised.

Pagefault response: oLDST_PAGEFAULT=1, oLDST_DATA=0, MMU flags passed through.

Flush:
- iFLUSH in ISSUE, request not accepted that cycle: drop REQ, go to IDLE.
- iFLUSH in ISSUE in the same cycle the request is accepted (!iDATAIO_BUSY): go to DRAIN.
- iFLUSH in WAIT: go to DRAIN. If the response arrives that same cycle, discard it and go to IDLE.
- iFLUSH in IDLE: takes priority over iLDST_REQ; no request is accepted.
- No VALID is emitted for a flushed access.

## Timing
- Reset: state=IDLE. oLDST_BUSY, oLDST_VALID, oLDST_PAGEFAULT, oDATAIO_REQ = 0. All data, flag and field outputs = 0.
- Accept at cycle T (iLDST_REQ && !oLDST_BUSY). oDATAIO_REQ rises at T+1.
- Response seen at cycle R. oLDST_VALID is a registered pulse at R+1, and oLDST_BUSY falls at R+1.
- Minimum round trip: memory accepts at T+1 and responds at T+2, giving VALID at T+3.
- A new request can be accepted in the VALID cycle.
- oDATAIO_* fields are stable for the whole time REQ is high.
- iDATAIO_REQ while in IDLE or ISSUE is ignored.

## Structure
- Shared core package holds the ORDER encodings, the lane-mask function and the state encoding.
- One sub-module, `load_store_lane_format`, is purely combinational: write-data replication, mask generation and read extraction. It is instantiated once and driven from the latched request.

## Test plan
- Byte write, addr=0x1003, data=0xAB → DATAIO_ADDR=0x1000, MASK=0001, DATA=0xABABABAB. Response at +1 → VALID pulse 3 cycles after accept.
- Half read, addr=0x2002, memory returns 0x11223344 → oLDST_DATA=0x00003344. Same access at addr=0x2000 → 0x00001122.
- iDATAIO_BUSY held for 5 cycles → REQ and all fields stable throughout, BUSY stays high, exactly one transaction issued.
- Read response with PAGEFAULT=1, flags=0x1234 → VALID=1, PAGEFAULT=1, DATA=0, MMU_FLAGS=0x1234.
- Flush in WAIT, response 3 cycles later → no VALID, BUSY falls the cycle after the response. A request in the following cycle is accepted normally.
- iRESET_SYNC asserted in WAIT → next cycle all outputs are 0 and state is IDLE. A late iDATAIO_REQ is ignored.
